dffr_pipe_bank: RTL and testbench



---
 rtl/dffr_pipe_bank.sv | 93 +++++++++
 tb/tb_dffr_pipe_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dffr_pipe_bank.sv
// dffr_pipe_bank: WIDTH-bit, DEPTH-stage resettable register pipeline.
// Each stage carries a data word and a valid bit. The bank supports stall
// (E=0), flush of all valids, and a full serial scan chain through every
// data bit. Edge priority is R > SE > FLUSH > E > hold. Every output is
// taken from a register, so there is no path from an input to an output.
module dffr_pipe_bank #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                             CLK,
   input  logic                             R,
   input  logic                             E,
   input  logic [WIDTH-1:0]                 D,
   input  logic                             DV,
   input  logic                             FLUSH,
   input  logic                             SE,
   input  logic                             SI,
   output logic [WIDTH-1:0]                 Q,
   output logic                             QV,
   output logic [$clog2(DEPTH+1)-1:0]       OCC,
   output logic                             SO
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int TOTAL = DEPTH * WIDTH;

   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] v;

   // Scan chain view of the data registers: stage 0 bit 0 is the LSB,
   // the last stage's MSB is the bit that leaves on SO.
   logic [TOTAL-1:0] chain;
   logic [TOTAL-1:0] chain_shift;

   // Pack the stage registers into one flat scan vector.
   always_comb begin
      // NOTE: every variable driven here gets a full default first so no latch can be inferred.
      chain = '0;
      for (int i = 0; i < DEPTH; i++) begin
         chain[i*WIDTH +: WIDTH] = data[i];
      end
   end

   // One scan shift: SI enters at bit 0 and the old top bit falls off.
   assign chain_shift = TOTAL'({chain, SI});

   // Data and valid state update with R > SE > FLUSH > E priority.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples its neighbour's pre-edge value.
      if (R) begin
         // NOTE: the data array is reset on purpose: RESET_VAL is architecturally visible on Q and SO.
         for (int i = 0; i < DEPTH; i++) begin
            data[i] <= RESET_VAL;
         end
         v <= '0;
      end else if (SE) begin
         // Scan mode shifts data only; valids are frozen.
         for (int i = 0; i < DEPTH; i++) begin
            data[i] <= chain_shift[i*WIDTH +: WIDTH];
         end
      end else begin
         // Data advances on E even while a flush clears the valids.
         if (E) begin
            data[0] <= D;
            for (int i = 1; i < DEPTH; i++) begin
               data[i] <= data[i-1];
            end
         end
         if (FLUSH) begin
            v <= '0;
         end else if (E) begin
            v[0] <= DV;
            for (int i = 1; i < DEPTH; i++) begin
               v[i] <= v[i-1];
            end
         end
      end
   end

   // Occupancy is the number of set valid bits, 0..DEPTH.
   always_comb begin
      OCC = '0;
      for (int i = 0; i < DEPTH; i++) begin
         OCC = OCC + OCC_W'(v[i]);
      end
   end

   assign Q  = data[DEPTH-1];
   assign QV = v[DEPTH-1];
   assign SO = chain[TOTAL-1];

endmodule

// File: tb/tb_dffr_pipe_bank.sv
// Bench for dffr_pipe_bank: two 8x4 instances sharing stimulus (reset
// values 8'hA5 and 0) plus a 1x1 instance with its own inputs. The 8x4
// reference model keeps the whole bank as one 32-bit word (stage i in
// bits 8i+7..8i) and a 4-bit valid vector, updated with plain shifts.
module tb_dffr_pipe_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus for the 8x4 instances
   logic       r, e, dv, flush, se, si;
   logic [7:0] d;
   logic [7:0] q_a, q_b;
   logic       qv_a, qv_b, so_a, so_b;
   logic [2:0] occ_a, occ_b;

   // Stimulus for the 1x1 instance
   logic c_r, c_e, c_d, c_dv, c_flush, c_se, c_si;
   logic c_q, c_qv, c_occ, c_so;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] mw_a, mw_b;
   logic [3:0]  mv;

   dffr_pipe_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut_a (
      .CLK(clk), .R(r), .E(e), .D(d), .DV(dv), .FLUSH(flush), .SE(se), .SI(si),
      .Q(q_a), .QV(qv_a), .OCC(occ_a), .SO(so_a));

   dffr_pipe_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_b (
      .CLK(clk), .R(r), .E(e), .D(d), .DV(dv), .FLUSH(flush), .SE(se), .SI(si),
      .Q(q_b), .QV(qv_b), .OCC(occ_b), .SO(so_b));

   dffr_pipe_bank #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut_c (
      .CLK(clk), .R(c_r), .E(c_e), .D(c_d), .DV(c_dv), .FLUSH(c_flush), .SE(c_se), .SI(c_si),
      .Q(c_q), .QV(c_qv), .OCC(c_occ), .SO(c_so));

   task automatic idle();
      r = 0; e = 0; dv = 0; flush = 0; se = 0; si = 0; d = 8'h00;
   endtask

   // One rising edge; the model absorbs the inputs present at that edge.
   // Outputs are observed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      if (r) begin
         mw_a = 32'hA5A5_A5A5;
         mw_b = 32'h0;
         mv   = 4'h0;
      end else if (se) begin
         mw_a = (mw_a << 1) | 32'(si);
         mw_b = (mw_b << 1) | 32'(si);
      end else begin
         if (e) begin
            mw_a = (mw_a << 8) | 32'(d);
            mw_b = (mw_b << 8) | 32'(d);
         end
         if (flush)  mv = 4'h0;
         else if (e) mv = (mv << 1) | 4'(dv);
      end
      #1;
   endtask

   task automatic test_reset();
      // Garbage first, no checks while the state is unknown
      for (int k = 0; k < 6; k++) begin
         r = 0; e = 1; d = 8'($urandom); dv = 1; flush = 0; se = 0; si = 1;
         tick();
      end
      r = 1;
      tick();
      idle();
      total++; if (q_a !== 8'hA5) begin bad++; $display("FAIL reset_q_a: got %h expected a5", q_a); end
      total++; if (qv_a !== 1'b0) begin bad++; $display("FAIL reset_qv_a: got %b expected 0", qv_a); end
      total++; if (occ_a !== 3'd0) begin bad++; $display("FAIL reset_occ_a: got %0d expected 0", occ_a); end
      total++; if (so_a !== 1'b1) begin bad++; $display("FAIL reset_so_a: got %b expected 1", so_a); end
      total++; if (q_b !== 8'h00) begin bad++; $display("FAIL reset_q_b: got %h expected 00", q_b); end
      total++; if (so_b !== 1'b0) begin bad++; $display("FAIL reset_so_b: got %b expected 0", so_b); end
   endtask

   task automatic test_stream();
      logic [7:0] seen[$];
      logic       st_e  [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
      logic [7:0] st_d  [10] = '{1, 2, 3, 3, 3, 4, 5, 0, 0, 0};
      logic       st_dv [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
      int         en_cnt = 0;
      int         max_occ = 0;
      idle(); r = 1; tick(); idle();
      for (int k = 0; k < 10; k++) begin
         e = st_e[k]; d = st_d[k]; dv = st_dv[k];
         tick();
         if (st_e[k]) en_cnt++;
         if (int'(occ_a) > max_occ) max_occ = int'(occ_a);
         total++;
         if (occ_a !== 3'($countones(mv))) begin
            bad++; $display("FAIL stream_occ step %0d: got %0d expected %0d", k, occ_a, $countones(mv));
         end
         if (en_cnt < 4) begin
            total++; if (qv_a !== 1'b0) begin bad++; $display("FAIL stream_early_qv step %0d: got %b expected 0", k, qv_a); end
         end else if (en_cnt == 4 && st_e[k]) begin
            total++; if (q_a !== 8'd1 || qv_a !== 1'b1) begin
               bad++; $display("FAIL stream_first_out: got q=%h qv=%b expected q=01 qv=1", q_a, qv_a);
            end
         end
         if (st_e[k] && qv_a === 1'b1) seen.push_back(q_a);
      end
      idle();
      total++; if (seen.size() != 5) begin bad++; $display("FAIL stream_count: got %0d expected 5", seen.size()); end
      for (int k = 0; k < 5 && k < seen.size(); k++) begin
         total++; if (seen[k] !== 8'(k + 1)) begin bad++; $display("FAIL stream_order[%0d]: got %h expected %h", k, seen[k], 8'(k + 1)); end
      end
      total++; if (max_occ != 4) begin bad++; $display("FAIL stream_occ_max: got %0d expected 4", max_occ); end
   endtask

   task automatic test_flush();
      idle(); r = 1; tick(); idle();
      for (int k = 0; k < 4; k++) begin
         e = 1; dv = 1; d = 8'($urandom);
         tick();
      end
      total++; if (occ_a !== 3'd4) begin bad++; $display("FAIL flush_fill_occ: got %0d expected 4", occ_a); end
      flush = 1; e = 1; d = 8'h77; dv = 1;
      tick();
      total++; if (occ_a !== 3'd0) begin bad++; $display("FAIL flush_occ: got %0d expected 0", occ_a); end
      total++; if (qv_a !== 1'b0) begin bad++; $display("FAIL flush_qv: got %b expected 0", qv_a); end
      flush = 0; e = 1; dv = 0;
      for (int k = 0; k < 3; k++) begin
         d = 8'($urandom);
         tick();
      end
      idle();
      total++; if (q_a !== 8'h77) begin bad++; $display("FAIL flush_data_shift: got %h expected 77", q_a); end
      total++; if (qv_a !== 1'b0) begin bad++; $display("FAIL flush_data_qv: got %b expected 0", qv_a); end
   endtask

   task automatic test_priority();
      idle(); r = 1; tick(); idle();
      for (int k = 0; k < 2; k++) begin e = 1; dv = 1; d = 8'($urandom); tick(); end
      r = 1; se = 1; flush = 1; e = 1; si = 0; dv = 1; d = 8'h3C;
      tick();
      idle();
      total++; if (q_a !== 8'hA5 || qv_a !== 1'b0 || occ_a !== 3'd0 || so_a !== 1'b1) begin
         bad++; $display("FAIL prio_reset: got q=%h qv=%b occ=%0d so=%b expected q=a5 qv=0 occ=0 so=1", q_a, qv_a, occ_a, so_a);
      end
      for (int k = 0; k < 3; k++) begin e = 1; dv = 1; d = 8'($urandom); tick(); end
      se = 1; flush = 1; e = 1; dv = 1; si = 1'($urandom); d = 8'($urandom);
      tick();
      idle();
      total++; if (occ_a !== 3'd3) begin bad++; $display("FAIL prio_scan_occ: got %0d expected 3", occ_a); end
      total++; if (q_a !== mw_a[31:24] || q_b !== mw_b[31:24]) begin
         bad++; $display("FAIL prio_scan_shift: got a=%h b=%h expected a=%h b=%h", q_a, q_b, mw_a[31:24], mw_b[31:24]);
      end
   endtask

   task automatic test_scan();
      idle(); r = 1; tick(); idle();
      for (int k = 0; k < 2; k++) begin e = 1; dv = 1; d = 8'h00; tick(); end
      idle();
      for (int k = 1; k <= 33; k++) begin
         se = 1; si = (k == 1);
         tick();
         total++;
         if (so_b !== (k == 32)) begin
            bad++; $display("FAIL scan_so edge %0d: got %b expected %b", k, so_b, (k == 32));
         end
         total++;
         if (occ_b !== 3'd2) begin
            bad++; $display("FAIL scan_occ edge %0d: got %0d expected 2", k, occ_b);
         end
      end
      idle();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         r     = ($urandom_range(0, 29) == 0);
         se    = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 7) == 0);
         e     = ($urandom_range(0, 2) != 0);
         dv    = 1'($urandom);
         si    = 1'($urandom);
         d     = 8'($urandom);
         tick();
         total++;
         if (q_a !== mw_a[31:24] || qv_a !== mv[3] || occ_a !== 3'($countones(mv)) || so_a !== mw_a[31]) begin
            bad++; $display("FAIL random_a cycle %0d: got q=%h qv=%b occ=%0d so=%b expected q=%h qv=%b occ=%0d so=%b",
                            k, q_a, qv_a, occ_a, so_a, mw_a[31:24], mv[3], $countones(mv), mw_a[31]);
         end
         total++;
         if (q_b !== mw_b[31:24] || qv_b !== mv[3] || occ_b !== 3'($countones(mv)) || so_b !== mw_b[31]) begin
            bad++; $display("FAIL random_b cycle %0d: got q=%h qv=%b occ=%0d so=%b expected q=%h qv=%b occ=%0d so=%b",
                            k, q_b, qv_b, occ_b, so_b, mw_b[31:24], mv[3], $countones(mv), mw_b[31]);
         end
      end
      idle();
   endtask

   task automatic test_depth1();
      logic seq_e [5] = '{1, 0, 1, 0, 1};
      logic seq_d [5] = '{1, 0, 0, 1, 1};
      logic exp_q;
      c_r = 1; c_e = 1; c_d = 0; c_dv = 1; c_flush = 0; c_se = 0; c_si = 0;
      tick();
      c_r = 0; c_e = 0;
      total++; if (c_q !== 1'b1 || c_qv !== 1'b0 || c_occ !== 1'b0 || c_so !== 1'b1) begin
         bad++; $display("FAIL d1_reset: got q=%b qv=%b occ=%b so=%b expected q=1 qv=0 occ=0 so=1", c_q, c_qv, c_occ, c_so);
      end
      exp_q = 1'b1;
      for (int k = 0; k < 5; k++) begin
         c_e = seq_e[k]; c_d = seq_d[k]; c_dv = 1;
         tick();
         if (seq_e[k]) exp_q = seq_d[k];
         total++; if (c_q !== exp_q || c_qv !== 1'b1 || c_occ !== 1'b1) begin
            bad++; $display("FAIL d1_follow step %0d: got q=%b qv=%b occ=%b expected q=%b qv=1 occ=1", k, c_q, c_qv, c_occ, exp_q);
         end
      end
      c_e = 0;
      for (int k = 0; k < 4; k++) begin
         c_se = 1; c_si = k[0];
         tick();
         total++; if (c_so !== k[0] || c_occ !== 1'b1) begin
            bad++; $display("FAIL d1_scan step %0d: got so=%b occ=%b expected so=%b occ=1", k, c_so, c_occ, k[0]);
         end
      end
      c_se = 0; c_si = 0;
   endtask

   initial begin
      idle();
      c_r = 1; c_e = 0; c_d = 0; c_dv = 0; c_flush = 0; c_se = 0; c_si = 0;
      mw_a = '0; mw_b = '0; mv = '0;
      test_reset();
      test_stream();
      test_flush();
      test_priority();
      test_scan();
      test_random();
      test_depth1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
